// File: rtl/uart_rx_fifo_if.sv
// Receive-side stream of the UART FIFO: head byte, valid, and consumer ready.
// master drives data/valid (the FIFO); slave drives ready (the consumer).
interface uart_rx_fifo_if;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;

  modport master (
    output outData,
    output outValid,
    input  outReady
  );

  modport slave (
    input  outData,
    input  outValid,
    output outReady
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small power-of-2 receive FIFO.
// Reset is synchronous and active-high.
module uart_rx_fifo #(
  parameter int unsigned CLOCK_RATE = 100000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  uart_rx_fifo_if.master         out_if,
  output logic                   rxBusy,
  output logic                   frameErr,
  output logic                   overrun,
  output logic [4:0]             fifoCount
);

  localparam int unsigned TICK_DIV_RAW = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int unsigned TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
  localparam int unsigned DIV_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [4:0]       DEPTH_CNT = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

  state_e           r_state, w_state_next;
  logic             r_rx_meta, r_line;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_tick_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [4:0]       r_count;
  logic             r_frame_err, r_overrun;

  logic w_tick, w_start_entry, w_tick_rst, w_sample_bit, w_push_req, w_frame_err;
  logic w_valid, w_pop, w_push, w_overrun;

  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_start_entry = 1'b0;
    w_tick_rst    = 1'b0;
    w_sample_bit  = 1'b0;
    w_push_req    = 1'b0;
    w_frame_err   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!r_line) begin
          w_state_next  = StStart;
          w_start_entry = 1'b1;
        end
      end
      StStart: begin
        // Mid start bit: a high line here was a glitch, not a frame.
        if (w_tick && r_tick_cnt == 4'd7) begin
          w_tick_rst   = 1'b1;
          w_state_next = r_line ? StIdle : StData;
        end
      end
      StData: begin
        if (w_tick && r_tick_cnt == 4'd15) begin
          w_sample_bit = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_next = StStop;
        end
      end
      StStop: begin
        if (w_tick && r_tick_cnt == 4'd15) begin
          if (r_line) begin
            w_push_req   = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (r_line) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_line     <= 1'b1;
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_meta <= rx;
      r_line    <= r_rx_meta;
      if (w_start_entry || w_tick) r_div_cnt <= '0;
      else                         r_div_cnt <= r_div_cnt + 1'b1;
      if (w_start_entry || w_tick_rst) r_tick_cnt <= '0;
      else if (w_tick)                 r_tick_cnt <= r_tick_cnt + 4'd1;
      if (w_start_entry)     r_bit_cnt <= '0;
      else if (w_sample_bit) r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_sample_bit) r_shift[r_bit_cnt] <= r_line;
    end
  end

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_valid   = (r_count != 5'd0);
  assign w_pop     = w_valid && out_if.outReady;
  assign w_push    = w_push_req && ((r_count < DEPTH_CNT) || w_pop);
  assign w_overrun = w_push_req && !w_push;

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 5'd1;
      else if (w_pop && !w_push) r_count <= r_count - 5'd1;
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
    end
  end

  assign out_if.outValid = w_valid;
  assign out_if.outData  = w_valid ? r_mem[r_rptr] : 8'h00;
  assign rxBusy          = (r_state != StIdle);
  assign frameErr        = r_frame_err;
  assign overrun         = r_overrun;
  assign fifoCount       = r_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 1.6 MHz / 10 kbaud (160 clk per bit).
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int unsigned CLK_RATE = 1600000;
  localparam int unsigned BAUD     = 10000;
  localparam int unsigned DEPTH    = 4;
  localparam int          BIT_CLKS = 160;
  // Negedges from the start-bit drive edge to the cycle whose closing edge samples the stop bit.
  localparam int          STOP_SAMPLE_NEG = 1522;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rxBusy, frameErr, overrun;
  logic [4:0] fifoCount;

  uart_rx_fifo_if u_if ();

  uart_rx_fifo #(
    .CLOCK_RATE (CLK_RATE),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .out_if    (u_if),
    .rxBusy    (rxBusy),
    .frameErr  (frameErr),
    .overrun   (overrun),
    .fifoCount (fifoCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  int n_fe     = 0;
  int n_ovr    = 0;
  logic [7:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: counts pulses and compares every popped byte with the scoreboard.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (frameErr) n_fe++;
      if (overrun)  n_ovr++;
      if (u_if.outValid && u_if.outReady) begin
        n_pops++;
        check_eq("pop_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("pop_data", 32'(u_if.outData), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) rx = 1'b0;
    repeat (BIT_CLKS - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = b[i];
      repeat (BIT_CLKS - 1) @(negedge clk);
    end
    @(negedge clk) rx = stop_bit;
    repeat (BIT_CLKS - 1) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    #2;
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"},   32'(u_if.outValid), 32'd0);
    check_eq({tag, "_data"},    32'(u_if.outData),  32'd0);
    check_eq({tag, "_busy"},    32'(rxBusy),        32'd0);
    check_eq({tag, "_ferr"},    32'(frameErr),      32'd0);
    check_eq({tag, "_ovr"},     32'(overrun),       32'd0);
    check_eq({tag, "_count"},   32'(fifoCount),     32'd0);
  endtask

  int p0, fe0, ov0, k;

  initial begin
    u_if.outReady = 1'b0;
    idle(4);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // Clean byte right after reset, consumer always ready.
    u_if.outReady = 1'b1;
    p0 = n_pops; fe0 = n_fe; ov0 = n_ovr;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(20);
    wait_drain("a5_drain", 200);
    check_eq("a5_pops",  32'(n_pops - p0), 32'd1);
    check_eq("a5_ferr",  32'(n_fe - fe0),  32'd0);
    check_eq("a5_ovr",   32'(n_ovr - ov0), 32'd0);
    check_eq("a5_count", 32'(fifoCount),   32'd0);

    // Short low glitch: busy briefly, then back to idle with no output.
    p0 = n_pops; fe0 = n_fe;
    @(negedge clk) rx = 1'b0;
    idle(5);
    #1;
    check_eq("glitch_busy", 32'(rxBusy), 32'd1);
    idle(25);
    rx = 1'b1;
    k = 0;
    while (rxBusy && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("glitch_idle", 32'(rxBusy),      32'd0);
    check_eq("glitch_pops", 32'(n_pops - p0), 32'd0);
    check_eq("glitch_ferr", 32'(n_fe - fe0),  32'd0);

    // Framing error followed by a held break.
    p0 = n_pops; fe0 = n_fe;
    send_frame(8'h3C, 1'b0);
    idle(400);
    #1;
    check_eq("break_busy",  32'(rxBusy),      32'd1);
    check_eq("break_ferr",  32'(n_fe - fe0),  32'd1);
    check_eq("break_pops",  32'(n_pops - p0), 32'd0);
    check_eq("break_count", 32'(fifoCount),   32'd0);
    @(negedge clk) rx = 1'b1;
    idle(10);
    #1;
    check_eq("break_release", 32'(rxBusy), 32'd0);

    // Fill with 0x01..0x04, 0x05 overruns, then drain in order.
    u_if.outReady = 1'b0;
    ov0 = n_ovr;
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
      idle(5);
    end
    #1;
    check_eq("fill_count",  32'(fifoCount),   32'd4);
    check_eq("fill_no_ovr", 32'(n_ovr - ov0), 32'd0);
    send_frame(8'h05, 1'b1);
    idle(5);
    #1;
    check_eq("ovr_pulse", 32'(n_ovr - ov0), 32'd1);
    check_eq("ovr_count", 32'(fifoCount),   32'd4);
    @(negedge clk) u_if.outReady = 1'b1;
    wait_drain("ovr_drain", 50);
    idle(2);
    #1;
    check_eq("ovr_drained", 32'(fifoCount), 32'd0);

    // Full FIFO, pop lands exactly in the stop-sample cycle of 0x77.
    @(negedge clk) u_if.outReady = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(8'(b * 8'h11));
      send_frame(8'(b * 8'h11), 1'b1);
      idle(5);
    end
    #1;
    check_eq("full_count", 32'(fifoCount), 32'd4);
    exp_q.push_back(8'h77);
    ov0 = n_ovr;
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(negedge clk);
        repeat (STOP_SAMPLE_NEG) @(negedge clk);
        u_if.outReady = 1'b1;
        @(negedge clk);
        u_if.outReady = 1'b0;
        #1;
        check_eq("same_cycle_count", 32'(fifoCount), 32'd4);
        check_eq("same_cycle_ovr",   32'(overrun),   32'd0);
      end
    join
    idle(5);
    #1;
    check_eq("same_cycle_no_ovr", 32'(n_ovr - ov0), 32'd0);
    check_eq("same_cycle_left",   32'(exp_q.size()), 32'd4);
    @(negedge clk) u_if.outReady = 1'b1;
    wait_drain("same_cycle_drain", 50);

    // Reset during data bit 4 with a byte already queued.
    @(negedge clk) u_if.outReady = 1'b0;
    send_frame(8'h99, 1'b1);
    idle(5);
    #1;
    check_eq("pre_rst_count", 32'(fifoCount), 32'd1);
    @(negedge clk) rx = 1'b0;
    repeat (BIT_CLKS - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) rx = (i[0] == 1'b0);
      repeat (BIT_CLKS - 1) @(negedge clk);
    end
    @(negedge clk) rx = 1'b0;
    repeat (BIT_CLKS / 2 - 1) @(negedge clk);
    #1;
    check_eq("pre_rst_busy", 32'(rxBusy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk) rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    u_if.outReady = 1'b1;
    p0 = n_pops;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(10);
    wait_drain("post_rst_drain", 100);
    check_eq("post_rst_pops",  32'(n_pops - p0), 32'd1);
    check_eq("post_rst_count", 32'(fifoCount),   32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 100000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning the line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the receive FIFO entry count; the value is a power of 2, range 2..16.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line carrying 8N1 frames, LSB first, idle high.
REQ-007 SHALL have port outData, output, 8 bits: the byte at the FIFO head.
REQ-008 SHALL have port outValid, output, 1 bit: high when the FIFO is not empty.
REQ-009 SHALL have port outReady, input, 1 bit: consumer accept; a pop occurs when outValid && outReady.
REQ-010 SHALL have port rxBusy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port frameErr, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-013 SHALL have port fifoCount, output, 5 bits: number of entries held, 0..FIFO_DEPTH.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1; "line" below means the second flop's output.
REQ-015 SHALL derive tick = 16x baud; TICK_DIV = max(1, CLOCK_RATE/(BAUD_RATE*16)) using integer floor; the tick counter restarts at 0 on the entry to START.
REQ-016 SHALL implement the states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-017 IDLE: line==0 -> START; the tick counter and sample counter clear on this transition.
REQ-018 START: on the 8th tick (mid start bit), line==0 -> DATA, otherwise -> IDLE with no output activity (glitch reject).
REQ-019 DATA: every 16th tick, sample the line into shift-register bit [n], n = 0..7, LSB first; after bit 7 -> STOP.
REQ-020 STOP: on the 16th tick, sample the line; if 1, push the byte and go -> IDLE; if 0, pulse frameErr, discard the byte, and go -> WAIT_IDLE.
REQ-021 WAIT_IDLE: stay until line==1, then -> IDLE; a break condition shall not retrigger reception.
REQ-022 Push accepted if fifoCount<FIFO_DEPTH or a pop occurs in the same cycle; otherwise drop the byte and pulse overrun in the push cycle; FIFO contents are unchanged by a drop.
REQ-023 Simultaneous push and pop: fifoCount unchanged, the head advances, and the new byte is written at the tail.
REQ-024 Pop when empty is impossible (outValid=0); outReady is ignored when empty.
REQ-025 outValid rises the cycle after the push cycle; outData equals the head entry whenever outValid=1.
REQ-026 Read and write pointers wrap modulo FIFO_DEPTH; fifoCount is registered and exact at all times.
REQ-027 frameErr and overrun each last exactly 1 clk per event; otherwise they are 0.
REQ-028 Latency from the mid stop-bit sample to outValid is 1 clk when the FIFO is empty.

Reset
REQ-029 While rst=1 at a clk edge: state IDLE, synchronizer flops 1, counters 0, FIFO pointers 0; outValid=0, outData=0, rxBusy=0, frameErr=0, overrun=0, fifoCount=0.
REQ-030 Reset mid-frame or mid-FIFO-drain aborts all activity; partial bytes and FIFO contents are discarded.
REQ-031 The first frame after rst deasserts is received normally, with no extra idle time required beyond line==1 at the start edge.

Verification (CLOCK_RATE=1600000, BAUD_RATE=10000 -> TICK_DIV=10, 160 clk/bit)
REQ-032 Send 0xA5 with outReady=1 -> one outValid cycle with outData=0xA5, frameErr=0, overrun=0, fifoCount returns to 0.
REQ-033 Drive rx low for 30 clk then high -> rxBusy high then back to 0 within 100 clk, no outValid, no frameErr.
REQ-034 Send 0x3C with stop bit=0, hold rx low 400 clk, then release -> frameErr single pulse, no push, rxBusy stays 1 until the line returns high.
REQ-035 outReady=0, send 0x01..0x05 -> fifoCount=4, overrun pulse on 0x05; then outReady=1 drains 0x01,0x02,0x03,0x04 in order.
REQ-036 FIFO full, outReady=1 asserted in the exact stop-sample cycle of byte 0x77 -> no overrun, fifoCount stays 4, 0x77 is read last.
REQ-037 Assert rst for 1 clk during DATA bit 4 -> all outputs at reset values next cycle; a following clean 0x5A frame is received as 0x5A.
